pcs_rx_block_lock: RTL
======================

PCS_RX_BLOCK_LOCK -- requirements
Module: pcs_rx_block_lock

Interface
REQ-001 SHALL have parameter HDR_WIDTH, default 2, sync header width in bits (only 2 supported).
REQ-002 SHALL have parameter BITSLIP_HIGH_CYCLES, default 1, cycles serdes_rx_bitslip is held high per slip (>=1).
REQ-003 SHALL have parameter BITSLIP_LOW_CYCLES, default 8, blanking cycles after each slip pulse (>=1).
REQ-004 SHALL have port rx_clk  input  1  single clock for all logic.
REQ-005 SHALL have port rx_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port serdes_rx_hdr  input  HDR_WIDTH  sync header from SERDES/gearbox.
REQ-007 SHALL have port serdes_rx_hdr_valid  input  1  header qualifier; header sampled only when high.
REQ-008 SHALL have port serdes_rx_bitslip  output  1  slip request to SERDES, registered.
REQ-009 SHALL have port rx_block_lock  output  1  block lock status, registered.
REQ-010 SHALL have port rx_sh_invalid  output  1  one-cycle pulse, registered: sampled header was invalid.
REQ-011 SHALL have port rx_lock_loss_count  output  8  count of LOCKED->unlocked transitions (see Configuration).

Function
REQ-012 Valid header SHALL be 2'b01 or 2'b10; 2'b00 and 2'b11 SHALL be invalid.
REQ-013 FSM states SHALL be UNLOCKED, SLIP_HIGH, SLIP_WAIT, LOCKED; all transitions on rx_clk rising edge.
REQ-014 Internal counters: sh_cnt 7-bit (0..64), sh_inv_cnt 5-bit (0..16), slip_cnt sized for max(BITSLIP_HIGH_CYCLES, BITSLIP_LOW_CYCLES).
REQ-015 UNLOCKED: each sampled valid header SHALL increment sh_cnt; when the 64th consecutive valid header is sampled, next state LOCKED, sh_cnt/sh_inv_cnt cleared.
REQ-016 UNLOCKED: a sampled invalid header SHALL clear sh_cnt and move to SLIP_HIGH.
REQ-017 SLIP_HIGH: serdes_rx_bitslip=1 for exactly BITSLIP_HIGH_CYCLES cycles, then SLIP_WAIT; headers ignored, counters held at 0.
REQ-018 SLIP_WAIT: serdes_rx_bitslip=0 for exactly BITSLIP_LOW_CYCLES cycles, headers ignored, then UNLOCKED.
REQ-019 LOCKED: rx_block_lock=1; each sampled header increments sh_cnt, each invalid one also increments sh_inv_cnt.
REQ-020 LOCKED: when sh_inv_cnt reaches 16 within a 64-header window, next state SLIP_HIGH, rx_block_lock deasserted next cycle.
REQ-021 LOCKED: at the 64th header of a window with sh_inv_cnt<16, both counters cleared, state stays LOCKED.
REQ-022 If the 64th header of a window is the 16th invalid, loss of lock SHALL take precedence over window restart.
REQ-023 serdes_rx_hdr_valid=0 SHALL freeze sh_cnt/sh_inv_cnt in UNLOCKED/LOCKED; slip timers SHALL run regardless of hdr_valid.
REQ-024 rx_block_lock SHALL assert the cycle after the 64th valid header is sampled (latency 1).
REQ-025 rx_sh_invalid SHALL pulse one cycle after any invalid header sampled in UNLOCKED or LOCKED; never in SLIP_HIGH/SLIP_WAIT.
REQ-026 Period of repeated slips with continuously invalid headers SHALL be 1+BITSLIP_HIGH_CYCLES+BITSLIP_LOW_CYCLES cycles.

Reset
REQ-027 rx_rst_n low SHALL asynchronously force state UNLOCKED, all counters 0, serdes_rx_bitslip=0, rx_block_lock=0, rx_sh_invalid=0, rx_lock_loss_count=0.
REQ-028 Reset asserted mid-slip or while LOCKED SHALL abort immediately; no residual slip pulse after release.
REQ-029 First header SHALL be sampled on the first rx_clk rising edge after rx_rst_n deasserts.

Configuration
REQ-030 Macro PCS_RX_LOCK_STATS_EN defined: rx_lock_loss_count increments (saturating at 255) on each LOCKED->SLIP_HIGH transition.
REQ-031 Macro PCS_RX_LOCK_STATS_EN undefined: counter logic absent, rx_lock_loss_count tied to 8'h00; all other behaviour identical.

Verification
REQ-032 Headers alternating 2'b00 (5 cyc)/2'b11 (5 cyc), hdr_valid=1 -> rx_block_lock never 1, bitslip high 1 cycle every 10 cycles, rx_lock_loss_count=0.
REQ-033 Constant 2'b01, hdr_valid=1 after reset -> rx_block_lock=1 on cycle 65, serdes_rx_bitslip never asserted.
REQ-034 Locked, then 15 invalid headers in a 64-header window -> lock held; 16th invalid in same window -> rx_block_lock=0 next cycle, bitslip pulse, count=1 (macro on).
REQ-035 Unlocked, 63 valid then 1 invalid -> no lock, slip pulse; then 64 valid -> lock.
REQ-036 hdr_valid=0 every other cycle with valid headers -> lock after 64 sampled headers (cycle ~128), not 64 cycles.
REQ-037 rx_rst_n asserted during SLIP_HIGH and LOCKED -> all outputs 0 immediately (asynchronous), relock needs 64 fresh valid headers.

Source files
------------

// File: rtl/pcs_rx_block_lock.sv
// 64b/66b receive block lock: hunts for sync-header alignment by slipping the SERDES.
// Optional lock-loss statistics counter enabled by defining PCS_RX_LOCK_STATS_EN.
module pcs_rx_block_lock #(
  parameter int unsigned HDR_WIDTH           = 2,
  parameter int unsigned BITSLIP_HIGH_CYCLES = 1,
  parameter int unsigned BITSLIP_LOW_CYCLES  = 8
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst_n,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 serdes_rx_hdr_valid,
  output logic                 serdes_rx_bitslip,
  output logic                 rx_block_lock,
  output logic                 rx_sh_invalid,
  output logic [7:0]           rx_lock_loss_count
);

  localparam int unsigned SH_W      = 7;
  localparam int unsigned INV_W     = 5;
  localparam int unsigned SH_WINDOW = 64;
  localparam int unsigned INV_LIMIT = 16;
  localparam int unsigned SLIP_MAX  = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                                      BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int unsigned SLIP_W    = (SLIP_MAX > 1) ? $clog2(SLIP_MAX) : 1;

  typedef enum logic [1:0] {UNLOCKED, SLIP_HIGH, SLIP_WAIT, LOCKED} state_t;

  state_t              state, state_nxt;
  logic [SH_W-1:0]     sh_cnt, sh_cnt_nxt, sh_cnt_inc;
  logic [INV_W-1:0]    sh_inv_cnt, sh_inv_cnt_nxt, sh_inv_inc;
  logic [SLIP_W-1:0]   slip_cnt, slip_cnt_nxt;
  logic                hdr_ok;
  logic                sh_invalid_nxt;

  assign hdr_ok     = (serdes_rx_hdr == HDR_WIDTH'(2'b01)) || (serdes_rx_hdr == HDR_WIDTH'(2'b10));
  assign sh_cnt_inc = sh_cnt + SH_W'(1);
  assign sh_inv_inc = sh_inv_cnt + INV_W'(!hdr_ok);

  // Next-state and counter update
  always_comb begin
    state_nxt      = state;
    sh_cnt_nxt     = sh_cnt;
    sh_inv_cnt_nxt = sh_inv_cnt;
    slip_cnt_nxt   = slip_cnt;
    sh_invalid_nxt = 1'b0;
    case (state)
      UNLOCKED: begin
        if (serdes_rx_hdr_valid) begin
          if (hdr_ok) begin
            if (sh_cnt_inc == SH_W'(SH_WINDOW)) begin
              state_nxt      = LOCKED;
              sh_cnt_nxt     = '0;
              sh_inv_cnt_nxt = '0;
            end else begin
              sh_cnt_nxt = sh_cnt_inc;
            end
          end else begin
            sh_invalid_nxt = 1'b1;
            sh_cnt_nxt     = '0;
            sh_inv_cnt_nxt = '0;
            slip_cnt_nxt   = '0;
            state_nxt      = SLIP_HIGH;
          end
        end
      end
      SLIP_HIGH: begin
        sh_cnt_nxt     = '0;
        sh_inv_cnt_nxt = '0;
        if (slip_cnt == SLIP_W'(BITSLIP_HIGH_CYCLES - 1)) begin
          slip_cnt_nxt = '0;
          state_nxt    = SLIP_WAIT;
        end else begin
          slip_cnt_nxt = slip_cnt + SLIP_W'(1);
        end
      end
      SLIP_WAIT: begin
        sh_cnt_nxt     = '0;
        sh_inv_cnt_nxt = '0;
        if (slip_cnt == SLIP_W'(BITSLIP_LOW_CYCLES - 1)) begin
          slip_cnt_nxt = '0;
          state_nxt    = UNLOCKED;
        end else begin
          slip_cnt_nxt = slip_cnt + SLIP_W'(1);
        end
      end
      LOCKED: begin
        if (serdes_rx_hdr_valid) begin
          sh_invalid_nxt = !hdr_ok;
          // Loss of lock wins over a window restart on the same header
          if (sh_inv_inc == INV_W'(INV_LIMIT)) begin
            state_nxt      = SLIP_HIGH;
            sh_cnt_nxt     = '0;
            sh_inv_cnt_nxt = '0;
            slip_cnt_nxt   = '0;
          end else if (sh_cnt_inc == SH_W'(SH_WINDOW)) begin
            sh_cnt_nxt     = '0;
            sh_inv_cnt_nxt = '0;
          end else begin
            sh_cnt_nxt     = sh_cnt_inc;
            sh_inv_cnt_nxt = sh_inv_inc;
          end
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state             <= UNLOCKED;
      sh_cnt            <= '0;
      sh_inv_cnt        <= '0;
      slip_cnt          <= '0;
      serdes_rx_bitslip <= 1'b0;
      rx_block_lock     <= 1'b0;
      rx_sh_invalid     <= 1'b0;
    end else begin
      state             <= state_nxt;
      sh_cnt            <= sh_cnt_nxt;
      sh_inv_cnt        <= sh_inv_cnt_nxt;
      slip_cnt          <= slip_cnt_nxt;
      serdes_rx_bitslip <= (state_nxt == SLIP_HIGH);
      rx_block_lock     <= (state_nxt == LOCKED);
      rx_sh_invalid     <= sh_invalid_nxt;
    end
  end

`ifdef PCS_RX_LOCK_STATS_EN
  logic       lock_lost_c;
  logic [7:0] loss_cnt;

  assign lock_lost_c = (state == LOCKED) && (state_nxt == SLIP_HIGH);

  // Saturating count of lock losses
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      loss_cnt <= 8'h00;
    end else if (lock_lost_c && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign rx_lock_loss_count = loss_cnt;
`else
  assign rx_lock_loss_count = 8'h00;
`endif

endmodule
